// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master and its users.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START      = 4'd1,
    ADDR       = 4'd2,
    ADDR_ACK   = 4'd3,
    WDATA      = 4'd4,
    WDATA_ACK  = 4'd5,
    RDATA      = 4'd6,
    RDATA_NACK = 4'd7,
    STOP       = 4'd8
  } i2c_mstate_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;

  localparam logic [6:0] SWITCH_SLAVE_ADDR = 7'h57;

  function automatic int qdiv(input int clk_hz, input int i2c_hz);
    return clk_hz / (4 * i2c_hz);
  endfunction

endpackage

// File: rtl/i2c_master_byte_if.sv
// Host-side request/response bundle of the I2C byte master.
interface i2c_master_byte_if;
  logic       start;
  logic       rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       busy;
  logic       done;
  logic       ack_err;

  modport master (output start, rw, addr, wdata, input rdata, busy, done, ack_err);
  modport slave  (input start, rw, addr, wdata, output rdata, busy, done, ack_err);
endinterface

// File: rtl/i2c_master_qtick.sv
// Quarter-bit tick generator: qtick pulses on the last cycle of each quarter,
// quarter is the index (0..3) of the quarter currently running.
module i2c_master_qtick #(
  parameter int QDIV = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       clear,
  output logic       qtick,
  output logic [1:0] quarter
);
  localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QDIV - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    quarter_r;

  assign qtick   = enable && (cnt_r == CNT_LAST);
  assign quarter = quarter_r;

  // quarter counter and quarter index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r     <= {CW{1'b0}};
      quarter_r <= 2'd0;
    end else if (clear) begin
      cnt_r     <= {CW{1'b0}};
      quarter_r <= 2'd0;
    end else if (qtick) begin
      cnt_r     <= {CW{1'b0}};
      quarter_r <= quarter_r + 2'd1;
    end else if (enable) begin
      cnt_r     <= cnt_r + CW'(1);
      quarter_r <= quarter_r;
    end else begin
      cnt_r     <= cnt_r;
      quarter_r <= quarter_r;
    end
  end
endmodule

// File: rtl/i2c_master_byte.sv
// Single-byte I2C master: START, address, one data byte, STOP; SDA open-drain.
// Optional macro I2C_MASTER_DEBUG_EN exposes debug_state / debug_bit_cnt.
module i2c_master_byte
  import i2c_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int I2C_FREQ_HZ = 100_000
) (
  input  logic               clk,
  input  logic               rst_n,
  i2c_master_byte_if.slave   host,
  output logic               scl,
  inout  wire                sda
`ifdef I2C_MASTER_DEBUG_EN
  ,
  output logic [3:0]         debug_state,
  output logic [2:0]         debug_bit_cnt
`endif
);
  localparam int QDIV = qdiv(CLK_FREQ_HZ, I2C_FREQ_HZ);

  i2c_mstate_t state_r, state_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  shift_r, shift_s;
  logic [7:0]  rx_r, rx_s;
  logic [7:0]  wdata_r, wdata_s;
  logic [7:0]  rdata_r, rdata_s;
  logic        rw_r, rw_s;
  logic        samp_r, samp_s;
  logic        ack_err_r, ack_err_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        scl_r, scl_s;
  logic        sda_low_r, sda_low_s;
  logic [1:0]  sync_r;
  logic        qtick_s;
  logic [1:0]  quarter_s;
  logic [1:0]  q_next_s;
  logic        bit_end_s;

  i2c_master_qtick #(.QDIV(QDIV)) u_qtick (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (state_r != IDLE),
    .clear   (state_r == IDLE),
    .qtick   (qtick_s),
    .quarter (quarter_s)
  );

  // next-state, datapath and pin values (pins derived from the next state so they are registered without lag)
  always_comb begin
    state_s   = state_r;
    bit_cnt_s = bit_cnt_r;
    shift_s   = shift_r;
    rx_s      = rx_r;
    wdata_s   = wdata_r;
    rdata_s   = rdata_r;
    rw_s      = rw_r;
    samp_s    = samp_r;
    ack_err_s = ack_err_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    q_next_s  = quarter_s;
    bit_end_s = qtick_s && (quarter_s == 2'd3);
    scl_s     = 1'b1;
    sda_low_s = 1'b0;

    if (state_r == IDLE) begin
      // a start coinciding with done is dropped, not deferred
      if (host.start && !done_r) begin
        state_s   = START;
        shift_s   = {host.addr, host.rw};
        rw_s      = host.rw;
        wdata_s   = host.wdata;
        bit_cnt_s = 3'd7;
        ack_err_s = 1'b0;
        busy_s    = 1'b1;
      end else begin
        state_s = IDLE;
      end
    end else begin
      if (qtick_s) begin
        q_next_s = quarter_s + 2'd1;
      end else begin
        q_next_s = quarter_s;
      end
      if (qtick_s && (quarter_s == 2'd2)) begin
        samp_s = sync_r[1];
        if (state_r == RDATA) begin
          rx_s = {rx_r[6:0], sync_r[1]};
        end else begin
          rx_s = rx_r;
        end
      end else begin
        samp_s = samp_r;
      end
      if (bit_end_s) begin
        case (state_r)
          START: state_s = ADDR;
          ADDR: begin
            bit_cnt_s = bit_cnt_r - 3'd1;
            shift_s   = {shift_r[6:0], 1'b0};
            if (bit_cnt_r == 3'd0) state_s = ADDR_ACK;
            else                   state_s = ADDR;
          end
          ADDR_ACK: begin
            if (samp_r == I2C_NACK) begin
              ack_err_s = 1'b1;
              state_s   = STOP;
            end else if (rw_r == I2C_RW_READ) begin
              state_s = RDATA;
            end else begin
              state_s = WDATA;
              shift_s = wdata_r;
            end
          end
          WDATA: begin
            bit_cnt_s = bit_cnt_r - 3'd1;
            shift_s   = {shift_r[6:0], 1'b0};
            if (bit_cnt_r == 3'd0) state_s = WDATA_ACK;
            else                   state_s = WDATA;
          end
          WDATA_ACK: begin
            if (samp_r == I2C_NACK) ack_err_s = 1'b1;
            else                    ack_err_s = ack_err_r;
            state_s = STOP;
          end
          RDATA: begin
            bit_cnt_s = bit_cnt_r - 3'd1;
            if (bit_cnt_r == 3'd0) state_s = RDATA_NACK;
            else                   state_s = RDATA;
          end
          RDATA_NACK: state_s = STOP;
          STOP: begin
            state_s = IDLE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            if ((rw_r == I2C_RW_READ) && !ack_err_r) rdata_s = rx_r;
            else                                     rdata_s = rdata_r;
          end
          default: state_s = IDLE;
        endcase
      end else begin
        state_s = state_r;
      end
    end

    case (state_s)
      IDLE: begin
        scl_s     = 1'b1;
        sda_low_s = 1'b0;
      end
      START: begin
        scl_s     = 1'b1;
        sda_low_s = q_next_s[1];
      end
      ADDR, WDATA: begin
        scl_s     = q_next_s[1];
        sda_low_s = ~shift_s[7];
      end
      ADDR_ACK, WDATA_ACK, RDATA, RDATA_NACK: begin
        scl_s     = q_next_s[1];
        sda_low_s = 1'b0;
      end
      STOP: begin
        scl_s     = (q_next_s != 2'd0);
        sda_low_s = ~q_next_s[1];
      end
      default: begin
        scl_s     = 1'b1;
        sda_low_s = 1'b0;
      end
    endcase
  end

  // state and output registers; async reset releases the bus at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      rx_r      <= 8'h00;
      wdata_r   <= 8'h00;
      rdata_r   <= 8'h00;
      rw_r      <= 1'b0;
      samp_r    <= 1'b1;
      ack_err_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      scl_r     <= 1'b1;
      sda_low_r <= 1'b0;
      sync_r    <= 2'b11;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      shift_r   <= shift_s;
      rx_r      <= rx_s;
      wdata_r   <= wdata_s;
      rdata_r   <= rdata_s;
      rw_r      <= rw_s;
      samp_r    <= samp_s;
      ack_err_r <= ack_err_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      scl_r     <= scl_s;
      sda_low_r <= sda_low_s;
      sync_r    <= {sync_r[0], sda};
    end
  end

  assign scl          = scl_r;
  assign sda          = sda_low_r ? 1'b0 : 1'bz;
  assign host.rdata   = rdata_r;
  assign host.busy    = busy_r;
  assign host.done    = done_r;
  assign host.ack_err = ack_err_r;

`ifdef I2C_MASTER_DEBUG_EN
  assign debug_state   = state_r;
  assign debug_bit_cnt = bit_cnt_r;
`endif
endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: quarter-level bus model compared every cycle, plus a frame monitor.
module tb_i2c_master_byte;
  import i2c_pkg::*;

  localparam int CLK_HZ = 8_000_000;
  localparam int I2C_HZ = 500_000;
  localparam int Q      = CLK_HZ / (4 * I2C_HZ);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic slave_low = 1'b0;
  logic scl;
  wire  sda;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  i2c_master_byte_if bus ();

`ifdef I2C_MASTER_DEBUG_EN
  logic [3:0] dbg_state;
  logic [2:0] dbg_bit_cnt;
`endif

  i2c_master_byte #(.CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .host  (bus),
    .scl   (scl),
    .sda   (sda)
`ifdef I2C_MASTER_DEBUG_EN
    ,
    .debug_state   (dbg_state),
    .debug_bit_cnt (dbg_bit_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // expected bus per quarter: scl level, master pulling low, slave pulling low
  logic e_scl[$];
  logic e_ml[$];
  logic e_sl[$];
  logic [7:0] mon_bytes[$];
  logic       mon_acks[$];
  int start_cnt = 0;
  int stop_cnt  = 0;
  logic [7:0] model_rdata = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_q(input logic s, input logic m, input logic sl);
    e_scl.push_back(s);
    e_ml.push_back(m);
    e_sl.push_back(sl);
  endtask

  task automatic push_bit(input logic m, input logic sl);
    push_q(1'b0, m, sl); push_q(1'b0, m, sl); push_q(1'b1, m, sl); push_q(1'b1, m, sl);
  endtask

  task automatic build(input logic rw, input logic [6:0] a, input logic [7:0] wd,
                       input logic ack_a, input logic ack_d, input logic [7:0] rb);
    logic [7:0] ab;
    ab = {a, rw};
    e_scl.delete(); e_ml.delete(); e_sl.delete();
    push_q(1'b1, 1'b0, 1'b0); push_q(1'b1, 1'b0, 1'b0);
    push_q(1'b1, 1'b1, 1'b0); push_q(1'b1, 1'b1, 1'b0);
    for (int i = 7; i >= 0; i--) push_bit(!ab[i], 1'b0);
    push_bit(1'b0, ack_a);
    if (ack_a) begin
      if (rw == I2C_RW_WRITE) begin
        for (int i = 7; i >= 0; i--) push_bit(!wd[i], 1'b0);
        push_bit(1'b0, ack_d);
      end else begin
        for (int i = 7; i >= 0; i--) push_bit(1'b0, !rb[i]);
        push_bit(1'b0, 1'b0);
      end
    end
    push_q(1'b0, 1'b1, 1'b0); push_q(1'b1, 1'b1, 1'b0);
    push_q(1'b1, 1'b0, 1'b0); push_q(1'b1, 1'b0, 1'b0);
  endtask

  // frame monitor: START/STOP counting, byte+ack decode, SCL fall spacing
  initial begin
    logic ps, pd, sv;
    int bitn, cyc, last_fall;
    logic [7:0] msh;
    ps = 1'b1; pd = 1'b1; bitn = 0; cyc = 0; last_fall = -1; msh = 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      sv = (sda === 1'b0) ? 1'b0 : 1'b1;
      if (!rst_n) begin
        bitn = 0;
        last_fall = -1;
      end else begin
        if (ps && scl && pd && !sv) begin
          start_cnt++;
          bitn = 0;
          last_fall = -1;
        end
        if (ps && scl && !pd && sv) stop_cnt++;
        if (!ps && scl) begin
          if (bitn < 8) begin
            msh = {msh[6:0], sv};
            bitn++;
          end else begin
            mon_bytes.push_back(msh);
            mon_acks.push_back(sv);
            bitn = 0;
          end
        end
        if (ps && !scl) begin
          if (last_fall >= 0) chk("scl_period", 32'(cyc - last_fall), 32'(4 * Q));
          last_fall = cyc;
        end
      end
      ps = scl;
      pd = sv;
    end
  end

  task automatic run_txn(input string tag, input logic rw, input logic [6:0] a, input logic [7:0] wd,
                         input logic ack_a, input logic ack_d, input logic [7:0] rb,
                         input int poke_k, input int rst_k);
    int nc;
    logic exp_err, exp_sda;
    build(rw, a, wd, ack_a, ack_d, rb);
    exp_err = !ack_a || ((rw == I2C_RW_WRITE) && !ack_d);
    nc = e_scl.size() * Q;
    mon_bytes.delete();
    mon_acks.delete();
    @(negedge clk);
    bus.start = 1'b1; bus.rw = rw; bus.addr = a; bus.wdata = wd;
    for (int k = 0; k < nc; k++) begin
      @(negedge clk);
      if (k == poke_k) bus.start = 1'b1;
      else             bus.start = 1'b0;
      slave_low = e_sl[k / Q];
      if (k == rst_k) begin
        slave_low = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_scl"},  32'(scl), 32'(1));
        chk({tag, "_rst_sda"},  32'(sda), 32'(1));
        chk({tag, "_rst_busy"}, 32'(bus.busy), 32'(0));
        chk({tag, "_rst_done"}, 32'(bus.done), 32'(0));
        chk({tag, "_rst_rdata"}, 32'(bus.rdata), 32'(8'h00));
        model_rdata = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      #1;
      exp_sda = !(e_ml[k / Q] || e_sl[k / Q]);
      chk({tag, "_scl"},  32'(scl), 32'(e_scl[k / Q]));
      chk({tag, "_sda"},  32'(sda), 32'(exp_sda));
      chk({tag, "_busy"}, 32'(bus.busy), 32'(1));
      chk({tag, "_done"}, 32'(bus.done), 32'(0));
    end
    @(negedge clk);
    slave_low = 1'b0;
    #1;
    if ((rw == I2C_RW_READ) && ack_a) model_rdata = rb;
    chk({tag, "_done_end"},  32'(bus.done), 32'(1));
    chk({tag, "_busy_end"},  32'(bus.busy), 32'(0));
    chk({tag, "_ack_err"},   32'(bus.ack_err), 32'(exp_err));
    chk({tag, "_rdata"},     32'(bus.rdata), 32'(model_rdata));
    chk({tag, "_scl_idle"},  32'(scl), 32'(1));
    chk({tag, "_sda_idle"},  32'(sda), 32'(1));
  endtask

  initial begin
    int s0, p0;
    bus.start = 1'b0; bus.rw = 1'b0; bus.addr = 7'h00; bus.wdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_scl",     32'(scl), 32'(1));
    chk("reset_sda",     32'(sda), 32'(1));
    chk("reset_busy",    32'(bus.busy), 32'(0));
    chk("reset_done",    32'(bus.done), 32'(0));
    chk("reset_ack_err", 32'(bus.ack_err), 32'(0));
    chk("reset_rdata",   32'(bus.rdata), 32'(8'h00));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("rd_sw", I2C_RW_READ, SWITCH_SLAVE_ADDR, 8'h00, 1'b1, 1'b0, 8'hA5, -1, -1);
    chk("rd_sw_bits",   32'(e_scl.size() / 4), 32'(20));
    chk("rd_sw_nbytes", 32'(mon_bytes.size()), 32'(2));
    if (mon_bytes.size() == 2) begin
      chk("rd_sw_addr_byte", 32'(mon_bytes[0]), 32'(8'hAF));
      chk("rd_sw_addr_ack",  32'(mon_acks[0]), 32'(0));
      chk("rd_sw_data_byte", 32'(mon_bytes[1]), 32'(8'hA5));
      chk("rd_sw_data_nack", 32'(mon_acks[1]), 32'(1));
    end
    chk("rd_sw_rdata_lit", 32'(bus.rdata), 32'(8'hA5));

    run_txn("wr_nack", I2C_RW_WRITE, SWITCH_SLAVE_ADDR, 8'h12, 1'b0, 1'b0, 8'h00, -1, -1);
    chk("wr_nack_bits",    32'(e_scl.size() / 4), 32'(11));
    chk("wr_nack_err_lit", 32'(bus.ack_err), 32'(1));

    run_txn("wr_20", I2C_RW_WRITE, 7'h20, 8'h3C, 1'b1, 1'b1, 8'h00, -1, -1);
    chk("wr_20_nbytes", 32'(mon_bytes.size()), 32'(2));
    if (mon_bytes.size() == 2) begin
      chk("wr_20_addr_byte", 32'(mon_bytes[0]), 32'(8'h40));
      chk("wr_20_data_byte", 32'(mon_bytes[1]), 32'(8'h3C));
      chk("wr_20_acks",      32'({mon_acks[0], mon_acks[1]}), 32'(0));
    end
    chk("wr_20_rdata_kept", 32'(bus.rdata), 32'(8'hA5));
    bus.start = 1'b1; bus.rw = I2C_RW_READ; bus.addr = SWITCH_SLAVE_ADDR;
    @(negedge clk);
    bus.start = 1'b0;
    #1 chk("start_on_done_busy", 32'(bus.busy), 32'(0));
    @(negedge clk);
    #1 chk("start_on_done_busy2", 32'(bus.busy), 32'(0));

    s0 = start_cnt; p0 = stop_cnt;
    run_txn("wr_poke", I2C_RW_WRITE, 7'h20, 8'h81, 1'b1, 1'b1, 8'h00, 100, -1);
    chk("poke_starts", 32'(start_cnt - s0), 32'(1));
    chk("poke_stops",  32'(stop_cnt - p0), 32'(1));
    repeat (8) begin
      @(negedge clk);
      #1 chk("poke_idle_busy", 32'(bus.busy), 32'(0));
    end

    run_txn("rd_rst", I2C_RW_READ, SWITCH_SLAVE_ADDR, 8'h00, 1'b1, 1'b0, 8'h3C, -1, 197);
    repeat (2) @(negedge clk);
    run_txn("rd_5a", I2C_RW_READ, SWITCH_SLAVE_ADDR, 8'h00, 1'b1, 1'b0, 8'h5A, -1, -1);
    chk("rd_5a_rdata_lit", 32'(bus.rdata), 32'(8'h5A));

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
